// File: rtl/arbitro_vc_if.sv
// arbitro_vc_if: VC-FIFO heads/flags in, pops and destination pushes out.
interface arbitro_vc_if #(parameter int DATA_WIDTH = 6);
  logic                  enable;
  logic                  mode_rr;
  logic [3:0]            vc_empty;
  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic [DATA_WIDTH-1:0] vc2_data;
  logic [DATA_WIDTH-1:0] vc3_data;
  logic [3:0]            d_almost_full;
  logic [3:0]            vc_pop;
  logic [3:0]            d_push;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            grant_vc;
  logic [7:0]            pkt_count;
  logic                  busy;
  modport slave (
    input  enable, mode_rr, vc_empty, vc0_data, vc1_data, vc2_data, vc3_data, d_almost_full,
    output vc_pop, d_push, data_out, grant_vc, pkt_count, busy
  );
  modport master (
    output enable, mode_rr, vc_empty, vc0_data, vc1_data, vc2_data, vc3_data, d_almost_full,
    input  vc_pop, d_push, data_out, grant_vc, pkt_count, busy
  );
endinterface

// File: rtl/arbitro_vc.sv
// arbitro_vc: round-robin / fixed-priority drain of four VC FIFOs into four destination FIFOs.
module arbitro_vc #(parameter int DATA_WIDTH = 6) (
  input logic       clk,
  input logic       reset,
  arbitro_vc_if.slave bus
);
  logic [DATA_WIDTH-1:0] head [4];
  logic [3:0]            elig;
  logic [1:0]            base;
  logic [1:0]            g;
  logic                  found;
  logic [1:0]            ptr;
  logic [3:0]            d_push_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            grant_q;
  logic [7:0]            count_q;
  // reset also gates eligibility so nothing is popped while the FIFOs are being cleared
  always_comb begin
    head[0] = bus.vc0_data;
    head[1] = bus.vc1_data;
    head[2] = bus.vc2_data;
    head[3] = bus.vc3_data;
    for (int i = 0; i < 4; i++)
      elig[i] = !reset && bus.enable && !bus.vc_empty[i] && !bus.d_almost_full[head[i][DATA_WIDTH-1:DATA_WIDTH-2]];
    base  = bus.mode_rr ? ptr : 2'd0;
    found = 1'b0;
    g     = 2'd0;
    for (int k = 0; k < 4; k++)
      if (!found && elig[base + 2'(k)]) begin
        found = 1'b1;
        g     = base + 2'(k);
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      d_push_q <= '0;
      data_q   <= '0;
      grant_q  <= '0;
      count_q  <= '0;
      ptr      <= '0;
    end else begin
      d_push_q <= found ? 4'b0001 << head[g][DATA_WIDTH-1:DATA_WIDTH-2] : 4'b0000;
      if (found) begin
        data_q  <= head[g];
        grant_q <= g;
        count_q <= count_q + 8'd1;
        if (bus.mode_rr) ptr <= g + 2'd1;
      end
    end
  end
  assign bus.vc_pop    = found ? 4'b0001 << g : 4'b0000;
  assign bus.d_push    = d_push_q;
  assign bus.data_out  = data_q;
  assign bus.grant_vc  = grant_q;
  assign bus.pkt_count = count_q;
  assign bus.busy      = (|bus.vc_pop) || (|d_push_q);
endmodule
